// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential-PC fetch with an in-order PC-tagged return queue and redirect flush
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      epc_q [DEPTH];
  logic [31:0]      epc_d [DEPTH];
  logic [31:0]      ins_q [DEPTH];
  logic [31:0]      ins_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]    alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic [CW-1:0]    count_q, count_d, pend_q, pend_d, disc_q, disc_d;
  logic             grant, pop, rv_drop, rv_fill;

  // pending discards still occupy memory-side slots, so they consume credits
  assign imem_req    = rst_n & ~redirect_valid & ((count_q + disc_q) < CW'(DEPTH));
  assign imem_addr   = pc_q;
  assign fetch_valid = filled_q[head_q];
  assign fetch_instr = fetch_valid ? ins_q[head_q] : '0;
  assign fetch_pc    = fetch_valid ? epc_q[head_q] : '0;
  assign grant       = imem_req & imem_gnt;
  assign pop         = fetch_valid & fetch_ready;
  assign rv_drop     = imem_rvalid & (disc_q != '0);
  assign rv_fill     = imem_rvalid & (disc_q == '0) & (pend_q != '0);

  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    ins_d    = ins_q;
    filled_d = filled_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    head_d   = head_q;
    count_d  = count_q;
    pend_d   = pend_q;
    disc_d   = disc_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      filled_d = '0;
      alloc_d  = '0;
      fill_d   = '0;
      head_d   = '0;
      count_d  = '0;
      pend_d   = '0;
      disc_d   = disc_q + pend_q - CW'(imem_rvalid && ((disc_q + pend_q) != '0));
    end else begin
      if (grant) begin
        epc_d[alloc_q]    = pc_q;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + AW'(1);
        pc_d              = pc_q + 32'd4;
      end
      if (rv_fill) begin
        ins_d[fill_q]    = imem_rdata;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + AW'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + AW'(1);
      end
      count_d = count_q + CW'(grant) - CW'(pop);
      pend_d  = pend_q + CW'(grant) - CW'(rv_fill);
      disc_d  = disc_q - CW'(rv_drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      epc_q    <= '{default: '0};
      ins_q    <= '{default: '0};
      filled_q <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      disc_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      ins_q    <= ins_d;
      filled_q <= filled_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      disc_q   <= disc_d;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && disc_q == '0 && pend_q == '0));
endmodule
